prg_shift_out: RTL and testbench
================================

PRG_SHIFT_OUT -- requirements
Module: prg_shift_out

Interface
REQ-001 Parameter HALF_PERIOD, default 4: clk cycles per prg_shift_clk half-period; legal range 1..255.
REQ-002 Parameter LATCH_CYCLES, default 4: clk cycles prg_latch is held high per word; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  word offered for transmission.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 in_addr  input  8  target RAM address.
REQ-008 in_data  input  8  byte to write.
REQ-009 prg_din  output  1  serial data to the SoC program port.
REQ-010 prg_shift_clk  output  1  serial shift clock; receiver samples prg_din on its rising edge.
REQ-011 prg_latch  output  1  write strobe; high while the SoC performs the RAM write.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle pulse per completed word.

Function
REQ-014 The block SHALL implement states IDLE, SETUP, HIGH, LATCH and GAP.
REQ-015 in_ready SHALL equal (state == IDLE) and not reset, combinationally.
REQ-016 Handshake: word accepted on a rising edge where in_valid and in_ready are both high; in_addr/in_data are ignored at all other times.
REQ-017 On accept: 16-bit shift register loads {in_addr, in_data}; bit counter cleared; phase counter cleared; state becomes SETUP.
REQ-018 Bit order SHALL be MSB first: in_addr[7] first, in_data[0] last.
REQ-019 prg_din SHALL be driven directly from shift register bit 15.
REQ-020 SETUP: prg_shift_clk=0 for HALF_PERIOD cycles, then HIGH.
REQ-021 HIGH: prg_shift_clk=1 for HALF_PERIOD cycles; prg_din stable throughout.
REQ-022 At the end of HIGH: register shifts left one (zero fill); bit counter increments; next state is SETUP if fewer than 16 bits sent, else LATCH.
REQ-023 prg_din SHALL change only on the SETUP entry edge, never while prg_shift_clk=1; prg_din=0 in LATCH, GAP and IDLE.
REQ-024 LATCH: prg_latch=1, prg_shift_clk=0 for LATCH_CYCLES cycles, then GAP.
REQ-025 GAP: all serial outputs 0 for HALF_PERIOD cycles, then IDLE.
REQ-026 done SHALL be high for exactly the first IDLE cycle following GAP; never otherwise.
REQ-027 Timing (accept edge = cycle 0, H=HALF_PERIOD, L=LATCH_CYCLES): bit i low phase cycles 2iH+1..2iH+H, high phase 2iH+H+1..2(i+1)H; latch cycles 32H+1..32H+L; in_ready and done high at cycle 33H+L+1.
REQ-028 Back-to-back: a word presented with in_valid held high SHALL be accepted in the same cycle in_ready returns high; minimum word period is 33H+L+1 cycles.
REQ-029 prg_shift_clk and prg_latch SHALL never be high in the same cycle.
REQ-030 Phase counter SHALL be 8 bits and counts 0..N-1 per phase; bit counter SHALL be 5 bits (0..16).
REQ-031 All outputs except in_ready SHALL be registered (glitch-free; they drive pins).

Reset
REQ-032 While reset is high, on the next edge: state=IDLE, shift register=0, counters=0, prg_din=0, prg_shift_clk=0, prg_latch=0, busy=0, done=0; in_ready=0 while reset is asserted.
REQ-033 Reset asserted mid-word SHALL abort the word with no latch pulse; in_ready=1 in the first cycle after reset deasserts.

Verification
REQ-034 Single word, H=4, L=4: accept addr=0xA5, data=0x3C -> 16 rising prg_shift_clk edges sampling 1010010100111100, latch high cycles 129..132, done+in_ready at cycle 137.
REQ-035 Back-to-back: in_valid held high with words (0x00,0xFF) then (0xFF,0x00) -> second accept at cycle 137, bitstreams 0x00FF then 0xFF00, exactly two latch pulses, two done pulses.
REQ-036 Reset during bit 7 high phase -> outputs 0 next cycle, no prg_latch pulse, no done, in_ready=1 after reset release; next word transmits correctly.
REQ-037 H=1, L=1: word (0x12,0x34) -> prg_shift_clk toggles every cycle, latch cycle 33, done at cycle 35.
REQ-038 Loopback with a 16-bit serial receiver model sampling on prg_shift_clk rise and writing on prg_latch: 256 random {addr,data} words -> model memory matches sent data; prg_din never changes while prg_shift_clk=1; in_valid with in_ready=0 never changes output stream.

Source files
------------

// File: rtl/prg_shift_out.sv
// Serialises {addr, data} words MSB-first onto a three-wire SoC program port.
// Each word is followed by a latch strobe, then a quiet gap, before the next word is accepted.
module prg_shift_out #(
    parameter int HALF_PERIOD  = 4,
    parameter int LATCH_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_addr,
    input  logic [7:0] in_data,
    output logic       prg_din,
    output logic       prg_shift_clk,
    output logic       prg_latch,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_HIGH  = 3'd2;
    localparam logic [2:0] ST_LATCH = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam logic [7:0] HALF_LAST  = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] LATCH_LAST = 8'(LATCH_CYCLES - 1);
    localparam logic [4:0] LAST_BIT   = 5'd15;

    logic [2:0]  state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  phase_q, phase_d;
    logic        shift_clk_q;
    logic        latch_q;
    logic        busy_q;
    logic        done_q;
    logic        accept;

    assign in_ready = (state_q == ST_IDLE) && !reset;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q + 8'd1;
        case (state_q)
            ST_IDLE: begin
                phase_d = phase_q;
                if (accept) begin
                    shift_d   = {in_addr, in_data};
                    bit_cnt_d = 5'd0;
                    phase_d   = 8'd0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (phase_q == HALF_LAST) begin
                    phase_d = 8'd0;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                // Shifting on the falling edge of the serial clock keeps data
                // stable for the whole high phase; zero fill leaves din low afterwards.
                if (phase_q == HALF_LAST) begin
                    phase_d   = 8'd0;
                    shift_d   = {shift_q[14:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    state_d   = (bit_cnt_q == LAST_BIT) ? ST_LATCH : ST_SETUP;
                end
            end
            ST_LATCH: begin
                if (phase_q == LATCH_LAST) begin
                    phase_d = 8'd0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (phase_q == HALF_LAST) begin
                    phase_d = 8'd0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                phase_d = 8'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin outputs are registered from the next state so they switch on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= 16'd0;
            bit_cnt_q   <= 5'd0;
            phase_q     <= 8'd0;
            shift_clk_q <= 1'b0;
            latch_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            phase_q     <= phase_d;
            shift_clk_q <= (state_d == ST_HIGH);
            latch_q     <= (state_d == ST_LATCH);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_q == ST_GAP) && (state_d == ST_IDLE);
        end
    end

    assign prg_din       = shift_q[15];
    assign prg_shift_clk = shift_clk_q;
    assign prg_latch     = latch_q;
    assign busy          = busy_q;
    assign done          = done_q;

    a_no_clk_latch_overlap: assert property (@(posedge clk) !(prg_shift_clk && prg_latch));
    a_din_stable_high: assert property (@(posedge clk) disable iff (reset)
        (prg_shift_clk && $past(prg_shift_clk)) |-> $stable(prg_din));

endmodule

// File: tb/tb_prg_shift_out.sv
// Bench for prg_shift_out: scoreboard + serial receiver model on an H=4/L=4 instance,
// plus a directed timing run on an H=1/L=1 instance.
module tb_prg_shift_out;

    localparam int HA = 4;
    localparam int LA = 4;
    localparam int WA = 33 * HA + LA + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       reset, in_valid, in_ready, prg_din, prg_shift_clk, prg_latch, busy, done;
    logic [7:0] in_addr, in_data;

    logic       rst_b, valid_b, ready_b, din_b, sc_b, la_b, busy_b, done_b;
    logic [7:0] addr_b, data_b;

    prg_shift_out #(.HALF_PERIOD(HA), .LATCH_CYCLES(LA)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .prg_din(prg_din),
        .prg_shift_clk(prg_shift_clk), .prg_latch(prg_latch), .busy(busy), .done(done)
    );

    prg_shift_out #(.HALF_PERIOD(1), .LATCH_CYCLES(1)) dut_b (
        .clk(clk), .reset(rst_b), .in_valid(valid_b), .in_ready(ready_b),
        .in_addr(addr_b), .in_data(data_b), .prg_din(din_b),
        .prg_shift_clk(sc_b), .prg_latch(la_b), .busy(busy_b), .done(done_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] word;
        int          acc;
    } exp_t;

    exp_t       sb[$];
    int         dq[$];
    logic [7:0] ref_mem[256];
    bit         ref_wr[256];
    logic [7:0] rx_mem[256];
    int n_sent = 0, latch_count = 0, done_count = 0;
    int viol_overlap = 0, viol_din_hi = 0, viol_din_zero = 0;
    int last_acc = 0;
    bit chain_prev = 1'b0;

    // Receiver model: shifts prg_din in on each serial clock rise, writes its memory on latch.
    initial begin : monitor_a
        int          now_c, exp_done, rx_n, bit_err, latch_len;
        logic [15:0] rx_word;
        logic        prev_sc, prev_la, prev_din;
        exp_t        e;
        rx_n = 0; bit_err = 0; latch_len = 0; rx_word = 16'd0;
        prev_sc = 1'b0; prev_la = 1'b0; prev_din = 1'b0;
        forever begin
            @(negedge clk);
            now_c = cyc + 1;
            if (reset) begin
                rx_word = 16'd0; rx_n = 0; bit_err = 0; latch_len = 0;
            end else begin
                if (prg_shift_clk && prg_latch) viol_overlap++;
                if (prev_sc && prg_shift_clk && (prg_din !== prev_din)) viol_din_hi++;
                if ((prg_latch || !busy) && prg_din) viol_din_zero++;
                if (prg_shift_clk && !prev_sc) begin
                    if (sb.size() != 0 && now_c != sb[0].acc + 2 * rx_n * HA + HA + 1) bit_err++;
                    rx_word = {rx_word[14:0], prg_din};
                    rx_n++;
                end
                if (prg_latch && !prev_la) begin
                    latch_len = 1;
                    latch_count++;
                    rx_mem[rx_word[15:8]] = rx_word[7:0];
                    check("latch_has_word", int'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("bitstream", int'(rx_word), int'(e.word));
                        check("bit_count", rx_n, 16);
                        check("bit_timing_errs", bit_err, 0);
                        check("latch_start", now_c, e.acc + 32 * HA + 1);
                    end
                    rx_word = 16'd0; rx_n = 0; bit_err = 0;
                end else if (prg_latch) begin
                    latch_len++;
                end
                if (!prg_latch && prev_la) check("latch_len", latch_len, LA);
                if (done) begin
                    done_count++;
                    check("done_has_word", int'(dq.size() != 0), 1);
                    if (dq.size() != 0) begin
                        exp_done = dq.pop_front();
                        check("done_cycle", now_c, exp_done);
                        check("ready_at_done", int'(in_ready), 1);
                    end
                end
            end
            prev_sc = prg_shift_clk; prev_la = prg_latch; prev_din = prg_din;
        end
    end

    // mode 0: drop in_valid after accept; 1: hold in_valid with junk data; 2: random in_valid/junk.
    task automatic send(input logic [7:0] a, input logic [7:0] d, input int mode);
        int   acc;
        bit   got;
        exp_t e;
        in_valid = 1'b1; in_addr = a; in_data = d; got = 1'b0;
        for (int k = 0; k < 4 * WA && !got; k++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        check("accept_seen", int'(got), 1);
        if (!got) begin
            in_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        if (chain_prev) check("b2b_accept", acc, last_acc + WA);
        e.word = {a, d}; e.acc = acc;
        sb.push_back(e);
        dq.push_back(acc + WA);
        ref_mem[a] = d; ref_wr[a] = 1'b1;
        n_sent++;
        last_acc = acc; chain_prev = (mode != 0);
        @(posedge clk); #1;
        if (mode == 0) begin
            in_valid = 1'b0;
        end else begin
            repeat (WA - 1) begin
                in_valid = (mode == 1) ? 1'b1 : 1'($urandom);
                in_addr = 8'($urandom); in_data = 8'($urandom);
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin : stimulus
        bit         got;
        int         acc_b, tog_bad, mem_bad, mode;
        logic [15:0] wb;
        logic       sc_t[0:40], la_t[0:40], dn_t[0:40], di_t[0:40], rdy_t[0:40], bz_t[0:40];

        reset = 1'b1; in_valid = 1'b0; in_addr = 8'd0; in_data = 8'd0;
        rst_b = 1'b1; valid_b = 1'b0; addr_b = 8'd0; data_b = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_state", int'({prg_din, prg_shift_clk, prg_latch, busy, done, in_ready}), 0);
        #1 reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", int'(in_ready), 1);
        check("idle_busy", int'(busy), 0);
        @(posedge clk); #1;

        send(8'hA5, 8'h3C, 0);
        send(8'h00, 8'hFF, 1);
        send(8'hFF, 8'h00, 0);

        // Abort a word during the high phase of bit 7.
        in_valid = 1'b1; in_addr = 8'($urandom); in_data = 8'($urandom); got = 1'b0;
        for (int k = 0; k < 4 * WA && !got; k++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        check("abort_accept_seen", int'(got), 1);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (15 * HA) @(posedge clk);
        @(negedge clk);
        check("pre_abort_high", int'({prg_shift_clk, busy}), 3);
        #1 reset = 1'b1;
        @(negedge clk);
        check("abort_outputs", int'({prg_din, prg_shift_clk, prg_latch, busy, done, in_ready}), 0);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_ready", int'(in_ready), 1);
        check("abort_busy", int'({busy, done}), 0);
        chain_prev = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 256; i++) begin
            mode = (i == 255) ? 0 : int'($urandom_range(0, 2));
            send(8'($urandom), 8'($urandom), mode);
            if (mode == 0) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end

        got = 1'b0;
        for (int k = 0; k < 3 * WA && !got; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && dq.size() == 0) got = 1'b1;
        end
        check("drain", int'(got), 1);
        check("latch_count", latch_count, n_sent);
        check("done_count", done_count, n_sent);
        check("clk_latch_overlap", viol_overlap, 0);
        check("din_change_while_high", viol_din_hi, 0);
        check("din_nonzero_idle_latch", viol_din_zero, 0);
        mem_bad = 0;
        for (int a = 0; a < 256; a++)
            if (ref_wr[a] && (rx_mem[a] !== ref_mem[a])) mem_bad++;
        check("loopback_mem", mem_bad, 0);

        // H=1, L=1 instance: a single word with cycle-exact expectations.
        @(posedge clk); #1 rst_b = 1'b0;
        @(posedge clk); #1 valid_b = 1'b1; addr_b = 8'h12; data_b = 8'h34;
        @(negedge clk);
        check("b_ready", int'(ready_b), 1);
        acc_b = cyc + 1;
        @(posedge clk); #1 valid_b = 1'b0;
        for (int r = 1; r <= 40; r++) begin
            @(negedge clk);
            sc_t[r] = sc_b; la_t[r] = la_b; dn_t[r] = done_b;
            di_t[r] = din_b; rdy_t[r] = ready_b; bz_t[r] = busy_b;
        end
        check("b_cycle_index", cyc + 1 - acc_b, 40);
        tog_bad = 0;
        for (int r = 1; r <= 32; r++)
            if (sc_t[r] !== ((r % 2) == 0)) tog_bad++;
        check("b_toggle_errs", tog_bad, 0);
        wb = 16'd0;
        for (int i = 0; i < 16; i++) wb = {wb[14:0], di_t[2 * i + 2]};
        check("b_bits", int'(wb), 32'h1234);
        check("b_latch", int'({la_t[32], la_t[33], la_t[34]}), 2);
        check("b_done", int'({dn_t[34], dn_t[35], dn_t[36]}), 2);
        check("b_ready_at_done", int'({rdy_t[34], rdy_t[35]}), 1);
        check("b_busy_at_done", int'({bz_t[34], bz_t[35]}), 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
